// File: rtl/vliw_spi_target_if.sv
// Bundles the SPI pins and host-side TX/RX handshake of vliw_spi_target.
// master = initiator/host side, slave = the target itself.
`timescale 1ns/1ps
interface vliw_spi_target_if;
    logic       SCLK;
    logic       CS_n;
    logic       DI;
    logic       DO;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_pop;
    logic       overrun;
    logic       overrun_clr;
    logic       selected;

    modport master (
        output SCLK, CS_n, DI, tx_data, tx_load, rx_pop, overrun_clr,
        input  DO, tx_ready, rx_data, rx_valid, overrun, selected
    );

    modport slave (
        input  SCLK, CS_n, DI, tx_data, tx_load, rx_pop, overrun_clr,
        output DO, tx_ready, rx_data, rx_valid, overrun, selected
    );
endinterface

// File: rtl/vliw_spi_target.sv
// SPI mode-0 target, 8-bit MSB-first frames, pins oversampled in the clk domain.
// Define VLIW_SPI_TARGET_RXFIFO_EN for a 4-entry receive FIFO instead of one holding register.
`timescale 1ns/1ps
module vliw_spi_target (
    input  logic                    clk,
    input  logic                    rst_n,
    vliw_spi_target_if.slave        bus
);
    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t     r_state, w_state_nxt;
    logic       r_sclk_s1, r_sclk_s2, r_sclk_h;
    logic       r_cs_s1, r_cs_s2, r_cs_h;
    logic       r_di_s1, r_di_s2;
    logic       w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

    logic [6:0] r_shift_in, w_shift_in_nxt;
    logic [7:0] r_shift_out, w_shift_out_nxt;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic       r_byte_done, w_byte_done_nxt;

    logic [7:0] r_tx_hold;
    logic       r_tx_full;
    logic [7:0] w_tx_next;
    logic       w_tx_take;

    logic       w_push, w_push_ok, w_drop, w_pop, w_full, w_rx_valid;
    logic [7:0] w_push_data, w_rx_data;
    logic       r_overrun;

    // CS_n sync flops reset high so the target comes up deselected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_s1 <= 1'b0; r_sclk_s2 <= 1'b0; r_sclk_h <= 1'b0;
            r_cs_s1   <= 1'b1; r_cs_s2   <= 1'b1; r_cs_h   <= 1'b1;
            r_di_s1   <= 1'b0; r_di_s2   <= 1'b0;
        end else begin
            r_sclk_s1 <= bus.SCLK; r_sclk_s2 <= r_sclk_s1; r_sclk_h <= r_sclk_s2;
            r_cs_s1   <= bus.CS_n; r_cs_s2   <= r_cs_s1;   r_cs_h   <= r_cs_s2;
            r_di_s1   <= bus.DI;   r_di_s2   <= r_di_s1;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_h;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_h;
    assign w_cs_fall   = ~r_cs_s2 & r_cs_h;
    assign w_cs_rise   = r_cs_s2 & ~r_cs_h;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shift_in  <= 7'h00;
            r_shift_out <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_byte_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift_in  <= w_shift_in_nxt;
            r_shift_out <= w_shift_out_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_byte_done <= w_byte_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_in_nxt  = r_shift_in;
        w_shift_out_nxt = r_shift_out;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_byte_done_nxt = r_byte_done;
        w_tx_take       = 1'b0;
        w_push          = 1'b0;
        w_push_data     = {r_shift_in, r_di_s2};
        w_tx_next       = r_tx_full ? r_tx_hold : 8'h00;
        unique case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt     = S_SHIFT;
                    w_shift_out_nxt = w_tx_next;
                    w_tx_take       = r_tx_full;
                    w_bit_cnt_nxt   = 3'd0;
                    w_byte_done_nxt = 1'b0;
                end
            end
            S_SHIFT: begin
                if (w_cs_rise) begin
                    // a partial byte is simply abandoned
                    w_state_nxt     = S_IDLE;
                    w_bit_cnt_nxt   = 3'd0;
                    w_byte_done_nxt = 1'b0;
                end else if (w_sclk_rise) begin
                    w_shift_in_nxt = w_push_data[6:0];
                    w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_push          = 1'b1;
                        w_byte_done_nxt = 1'b1;
                    end
                end else if (w_sclk_fall) begin
                    // the falling edge after a byte's last bit fetches the next TX byte
                    if (r_byte_done) begin
                        w_shift_out_nxt = w_tx_next;
                        w_tx_take       = r_tx_full;
                        w_byte_done_nxt = 1'b0;
                    end else begin
                        w_shift_out_nxt = {r_shift_out[6:0], 1'b0};
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // take and load are exclusive: take needs full, load needs empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_hold <= 8'h00;
            r_tx_full <= 1'b0;
        end else if (w_tx_take) begin
            r_tx_full <= 1'b0;
        end else if (bus.tx_load && !r_tx_full) begin
            r_tx_hold <= bus.tx_data;
            r_tx_full <= 1'b1;
        end
    end

    assign w_pop     = bus.rx_pop & w_rx_valid;
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;

`ifdef VLIW_SPI_TARGET_RXFIFO_EN
    logic [7:0] r_mem [4];
    logic [1:0] r_wp, r_rp;
    logic [2:0] r_cnt;

    assign w_full     = (r_cnt == 3'd4);
    assign w_rx_valid = (r_cnt != 3'd0);
    assign w_rx_data  = r_mem[r_rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_mem[i] <= 8'h00;
            r_wp  <= 2'd0;
            r_rp  <= 2'd0;
            r_cnt <= 3'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wp] <= w_push_data;
                r_wp        <= r_wp + 2'd1;
            end
            if (w_pop) r_rp <= r_rp + 2'd1;
            case ({w_push_ok, w_pop})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
`else
    logic [7:0] r_rx_data;
    logic       r_rx_valid;

    assign w_full     = r_rx_valid;
    assign w_rx_valid = r_rx_valid;
    assign w_rx_data  = r_rx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else if (w_push_ok) begin
            r_rx_data  <= w_push_data;
            r_rx_valid <= 1'b1;
        end else if (w_pop) begin
            r_rx_valid <= 1'b0;
        end
    end
`endif

    // a drop in the same cycle as a clear leaves the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               r_overrun <= 1'b0;
        else if (w_drop)          r_overrun <= 1'b1;
        else if (bus.overrun_clr) r_overrun <= 1'b0;
    end

    assign bus.DO       = (r_state == S_SHIFT) & r_shift_out[7];
    assign bus.tx_ready = ~r_tx_full;
    assign bus.rx_data  = w_rx_data;
    assign bus.rx_valid = w_rx_valid;
    assign bus.overrun  = r_overrun;
    assign bus.selected = ~r_cs_s2;
endmodule

// File: tb/tb_vliw_spi_target.sv
// Scoreboard bench for vliw_spi_target: initiator tasks plus a TX/RX reference model,
// and an independent monitor that pops and checks received bytes.
`timescale 1ns/1ps
module tb_vliw_spi_target;
    localparam int HALF = 5;
`ifdef VLIW_SPI_TARGET_RXFIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vliw_spi_target_if bus();
    vliw_spi_target dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    bit         auto_pop = 1'b1;
    bit         m_full = 1'b0;
    logic [7:0] m_hold = 8'h00;
    logic [7:0] m_cur = 8'h00;
    bit         m_ovr = 1'b0;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // model: each byte slot takes the holding register if full, else sends zero
    task automatic take(output logic [7:0] v);
        v = m_full ? m_hold : 8'h00;
        m_full = 1'b0;
    endtask

    function automatic logic [3:0][7:0] pk4(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic host_load(input logic [7:0] v);
        chk1("tx_ready", bus.tx_ready, !m_full);
        bus.tx_data = v;
        bus.tx_load = 1'b1;
        tick(1);
        bus.tx_load = 1'b0;
        if (!m_full) begin
            m_full = 1'b1;
            m_hold = v;
        end
    endtask

    task automatic spi_byte(input logic [7:0] mosi, input int nbits,
                            input bit do_load, input logic [7:0] ld);
        logic [7:0] miso = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.DI = mosi[7-i];
            if (i == 7) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(mosi);
                else                      m_ovr = 1'b1;
            end
            tick(HALF);
            miso = {miso[6:0], bus.DO};
            bus.SCLK = 1'b1;
            if (i == 3 && do_load) host_load(ld);
            tick(HALF);
            bus.SCLK = 1'b0;
        end
        if (nbits == 8) begin
            chk8("miso", miso, m_cur);
            take(m_cur);
        end
    endtask

    task automatic frame(input int nb, input logic [3:0][7:0] mo,
                         input bit [3:0] lm, input logic [3:0][7:0] ld);
        bus.CS_n = 1'b0;
        take(m_cur);
        tick(6);
        chk1("selected", bus.selected, 1'b1);
        chk1("tx_ready_after_cs", bus.tx_ready, !m_full);
        for (int b = 0; b < nb; b++) spi_byte(mo[b], 8, lm[b], ld[b]);
        tick(5);
        bus.CS_n = 1'b1;
        tick(6);
        chk1("do_idle", bus.DO, 1'b0);
        chk1("deselected", bus.selected, 1'b0);
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || bus.rx_valid) && k < 100) begin
            tick(1);
            k++;
        end
        chk8("drain_left", 8'(exp_q.size()), 8'h00);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_DO"}, bus.DO, 1'b0);
        chk1({tag, "_tx_ready"}, bus.tx_ready, 1'b1);
        chk8({tag, "_rx_data"}, bus.rx_data, 8'h00);
        chk1({tag, "_rx_valid"}, bus.rx_valid, 1'b0);
        chk1({tag, "_overrun"}, bus.overrun, 1'b0);
        chk1({tag, "_selected"}, bus.selected, 1'b0);
    endtask

    // monitor: pops and checks whatever the DUT presents
    initial begin
        bus.rx_pop = 1'b0;
        forever begin
            @(negedge clk);
            bus.rx_pop = 1'b0;
            if (rst_n && auto_pop && bus.rx_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rx_unexpected: got %h expected none", bus.rx_data);
                end else begin
                    chk8("rx_data", bus.rx_data, exp_q.pop_front());
                end
                bus.rx_pop = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.SCLK = 1'b0; bus.CS_n = 1'b1; bus.DI = 1'b0;
        bus.tx_data = 8'h00; bus.tx_load = 1'b0; bus.overrun_clr = 1'b0;
        tick(3);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        tick(3);

        // preloaded 5A answers an A5 frame
        host_load(8'h5A);
        frame(1, pk4(8'hA5, 8'h00, 8'h00, 8'h00), 4'b0000, '0);
        wait_drain();

        // two bytes under one CS_n, C3 loaded during the first
        frame(2, pk4(8'h01, 8'h02, 8'h00, 8'h00), 4'b0001, pk4(8'hC3, 8'h00, 8'h00, 8'h00));
        wait_drain();

        // abort after 5 bits, then a clean 81
        bus.CS_n = 1'b0;
        take(m_cur);
        tick(6);
        spi_byte(8'hE7, 5, 1'b0, 8'h00);
        tick(5);
        bus.CS_n = 1'b1;
        tick(6);
        chk1("abort_DO", bus.DO, 1'b0);
        chk1("abort_rx_valid", bus.rx_valid, 1'b0);
        frame(1, pk4(8'h81, 8'h00, 8'h00, 8'h00), 4'b0000, '0);
        wait_drain();

        // overrun: DEPTH+1 unpopped bytes
        auto_pop = 1'b0;
        tick(2);
        for (int k = 0; k <= DEPTH; k++)
            frame(1, pk4(8'(8'h10 + k), 8'h00, 8'h00, 8'h00), 4'b0000, '0);
        tick(4);
        chk1("overrun_set", bus.overrun, m_ovr);
        chk1("overrun_rx_valid", bus.rx_valid, 1'b1);
        chk8("overrun_rx_data", bus.rx_data, exp_q[0]);
        bus.overrun_clr = 1'b1;
        tick(1);
        bus.overrun_clr = 1'b0;
        m_ovr = 1'b0;
        chk1("overrun_clr", bus.overrun, m_ovr);
        auto_pop = 1'b1;
        wait_drain();

        // no preload: all zeros on MISO
        frame(1, pk4(8'h96, 8'h00, 8'h00, 8'h00), 4'b0000, '0);
        wait_drain();

        // reset mid-frame after 3 bits, then a clean 3C
        host_load(8'h77);
        bus.CS_n = 1'b0;
        take(m_cur);
        tick(6);
        spi_byte(8'hFF, 3, 1'b0, 8'h00);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        m_full = 1'b0; m_ovr = 1'b0; exp_q.delete();
        bus.CS_n = 1'b1; bus.DI = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(3);
        frame(1, pk4(8'h3C, 8'h00, 8'h00, 8'h00), 4'b0000, '0);
        wait_drain();

        // randomized frames with random preloads and mid-byte loads
        for (int f = 0; f < 20; f++) begin
            logic [3:0][7:0] mo;
            logic [3:0][7:0] ld;
            bit   [3:0]      lm;
            int              nb;
            mo = $urandom();
            ld = $urandom();
            lm = 4'($urandom());
            nb = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) host_load(8'($urandom()));
            frame(nb, mo, lm, ld);
            chk1("overrun_rand", bus.overrun, m_ovr);
        end
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
